// File: rtl/mmio_uart_console.sv
// mmio_uart_console: data-port MMIO console. Byte stores to LOG_ADDR are queued
// and sent as UART frames on uart_tx; STATUS sits at LOG_ADDR+4; a store to
// EXIT_ADDR latches sticky done/pass flags.
// Optional build macro MMIO_UART_CONSOLE_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (11-bit frames instead of 10).
//
// Bus handshake: no valid/ready. mem_we is a one-cycle store strobe that is
// always accepted. Reads are address-only: mem_rdata presents, one cycle later,
// the register addressed in the previous cycle.
module mmio_uart_console #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] LOG_ADDR     = 32'h1000_0000,
  parameter logic [31:0] EXIT_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_CODE    = 32'h075B_CD15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        sim_done,
  output logic        sim_pass
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [31:0]   STATUS_ADDR = LOG_ADDR + 32'd4;
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_CONSOLE_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_e;

  // Address decode
  logic log_we, status_we, exit_we;
  assign log_we    = mem_we && (mem_addr == LOG_ADDR);
  assign status_we = mem_we && (mem_addr == STATUS_ADDR);
  assign exit_we   = mem_we && (mem_addr == EXIT_ADDR);

  // Log FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [7:0]    fifo_head;
  logic          full, empty, push, pop;
  logic [7:0]    occupancy;

  // TX state
  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          uart_tx_q, uart_tx_d;
  logic          cnt_last, tx_busy;
`ifdef MMIO_UART_CONSOLE_PARITY_EN
  logic          parity_q, parity_d;
`endif

  // Control/status registers
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   status_word;

  assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign fifo_head = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign occupancy = 8'(wr_ptr_q - rd_ptr_q);
  assign tx_busy   = (state_q != S_IDLE);
  assign cnt_last  = (cnt_q == CNT_LAST);

  // The transmitter takes the head whenever it is idle; a push into a full
  // FIFO is still accepted when that same cycle frees a slot.
  assign pop  = (state_q == S_IDLE) && !empty;
  assign push = log_we && (!full || pop);

  assign status_word = {16'b0, occupancy, 4'b0, ovf_q, tx_busy, empty, full};

  // FIFO pointers, overflow flag, exit flags and read-data mux
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    pass_d   = pass_q;
    rdata_d  = 32'b0;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (log_we && full && !pop)          ovf_d = 1'b1;
    else if (status_we && mem_wdata[3])  ovf_d = 1'b0;
    // Only the first exit store counts; later ones leave the verdict alone.
    if (exit_we && !done_q) begin
      done_d = 1'b1;
      pass_d = (mem_wdata == PASS_CODE);
    end
    if (mem_addr == STATUS_ADDR)     rdata_d = status_word;
    else if (mem_addr == EXIT_ADDR)  rdata_d = {31'b0, done_q};
  end

  // Register bank for FIFO control, flags and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      rdata_q  <= 32'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      rdata_q  <= rdata_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata[7:0];
  end

  // TX next state; the line level is a function of the current state and is
  // registered, so the wire follows the state by one cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    uart_tx_d = 1'b1;
`ifdef MMIO_UART_CONSOLE_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        uart_tx_d = 1'b1;
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        if (!empty) begin
          shift_d = fifo_head;
`ifdef MMIO_UART_CONSOLE_PARITY_EN
          parity_d = ^fifo_head;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        uart_tx_d = 1'b0;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        uart_tx_d = shift_q[0];
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_CONSOLE_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MMIO_UART_CONSOLE_PARITY_EN
      S_PARITY: begin
        uart_tx_d = parity_q;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        uart_tx_d = 1'b1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // TX FSM registers; reset aborts any frame in flight and idles the line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      uart_tx_q <= 1'b1;
`ifdef MMIO_UART_CONSOLE_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
`ifdef MMIO_UART_CONSOLE_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign mem_rdata = rdata_q;
  assign uart_tx   = uart_tx_q;
  assign sim_done  = done_q;
  assign sim_pass  = pass_q;

endmodule

// File: tb/tb_mmio_uart_console.sv
// tb_mmio_uart_console: self-checking bench for mmio_uart_console.
// Register-level vectors from a table, hand-written sequences for frame timing,
// overflow, exit and mid-frame reset, then random traffic checked against a
// queue-based reference model and a serial-line decoder.
module tb_mmio_uart_console;

  localparam int          CPB    = 4;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] LOG_A  = 32'h1000_0000;
  localparam logic [31:0] STAT_A = 32'h1000_0004;
  localparam logic [31:0] EXIT_A = 32'h2000_0000;
  localparam logic [31:0] PASS_C = 32'h075B_CD15;
`ifdef MMIO_UART_CONSOLE_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_rdata;
  logic        uart_tx, sim_done, sim_pass;

  initial forever #5 clk = ~clk;

  mmio_uart_console #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .LOG_ADDR    (LOG_A),
    .EXIT_ADDR   (EXIT_A),
    .PASS_CODE   (PASS_C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .uart_tx  (uart_tx),
    .sim_done (sim_done),
    .sim_pass (sim_pass)
  );

  // ---------------- scoreboard / counters ----------------
  int errors = 0;
  int checks = 0;
  int tcur   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, tcur);
    end
  endtask

  // ---------------- reference model ----------------
  // The console is modelled as a byte queue drained by a transmitter that is
  // occupied for FRAME cycles per byte and needs one idle cycle to pick up the
  // next one. Popped bytes land in exp_q, the order expected on the wire.
  logic [7:0]  mq[$];
  logic [7:0]  exp_q[$];
  int          next_free  = 0;
  int          busy_until = -1;
  bit          m_ovf, m_done, m_pass;
  logic [31:0] m_rdata = 32'h0;

  task automatic model_edge();
    logic [31:0] st;
    bit          pop_now;
    tcur++;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 0; m_done = 0; m_pass = 0; m_rdata = 32'h0;
      next_free = 0; busy_until = -1;
    end else begin
      st = 32'h0;
      st[0]    = (mq.size() == DEPTH);
      st[1]    = (mq.size() == 0);
      st[2]    = ((tcur - 1) <= busy_until);
      st[3]    = m_ovf;
      st[15:8] = 8'(mq.size());
      if (mem_addr == STAT_A)      m_rdata = st;
      else if (mem_addr == EXIT_A) m_rdata = {31'b0, m_done};
      else                         m_rdata = 32'h0;
      pop_now = (mq.size() > 0) && (tcur >= next_free);
      if (mem_we && mem_addr == LOG_A && mq.size() == DEPTH && !pop_now) m_ovf = 1;
      else if (mem_we && mem_addr == STAT_A && mem_wdata[3])             m_ovf = 0;
      if (pop_now) begin
        exp_q.push_back(mq.pop_front());
        next_free  = tcur + FRAME + 1;
        busy_until = tcur + FRAME - 1;
      end
      if (mem_we && mem_addr == LOG_A && mq.size() < DEPTH) mq.push_back(mem_wdata[7:0]);
      if (mem_we && mem_addr == EXIT_A && !m_done) begin
        m_done = 1;
        m_pass = (mem_wdata == PASS_C);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("rdata_model", mem_rdata, m_rdata);
    check("done_model", sim_done, m_done);
    check("pass_model", sim_pass, m_pass);
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_we = we; mem_addr = a; mem_wdata = d;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((mq.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      idle(1);
      n++;
    end
    idle(4);
    checks++;
    if (mq.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d bytes outstanding expected 0", name, mq.size() + exp_q.size());
    end
  endtask

  // ---------------- serial-line decoder ----------------
  bit         mon_en   = 1;
  int         rx_count = 0;
  logic [7:0] rx_last  = 8'h00;

  task automatic mon_wait(input int n, inout bit abort);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst || !mon_en) abort = 1;
    end
  endtask

  initial begin
    bit         ab;
    logic [7:0] b;
    logic       s, stp, par;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_tx === 1'b0) begin
        ab = 0; b = 8'h00; par = 1'b0;
        mon_wait(CPB / 2, ab);
        s = uart_tx;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB, ab);
          b[i] = uart_tx;
        end
`ifdef MMIO_UART_CONSOLE_PARITY_EN
        mon_wait(CPB, ab);
        par = uart_tx;
`endif
        mon_wait(CPB, ab);
        stp = uart_tx;
        if (!ab) begin
          check("rx_start_bit", s, 1'b0);
          check("rx_stop_bit", stp, 1'b1);
`ifdef MMIO_UART_CONSOLE_PARITY_EN
          check("rx_parity_bit", par, ^b);
`endif
          rx_count++;
          rx_last = b;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected_frame: got %h expected no frame", b);
          end else begin
            check("rx_byte", b, exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- register vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_done;
    logic        exp_pass;
  } vec_t;

  vec_t vt[9];

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] fv;
    logic [7:0]  ch;
    int          rx0, k_end;
    bit          saw_low;

    vt[0] = '{1'b0, STAT_A,           32'h0,        32'h0000_0002, 1'b0, 1'b0};
    vt[1] = '{1'b0, EXIT_A,           32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vt[2] = '{1'b0, 32'h0000_1234,    32'h0,        32'h0000_0000, 1'b0, 1'b0};
    vt[3] = '{1'b1, EXIT_A,           32'h1,        32'h0000_0000, 1'b1, 1'b0};
    vt[4] = '{1'b0, EXIT_A,           32'h0,        32'h0000_0001, 1'b1, 1'b0};
    vt[5] = '{1'b1, EXIT_A,           PASS_C,       32'h0000_0001, 1'b1, 1'b0};
    vt[6] = '{1'b1, STAT_A,           32'h8,        32'h0000_0002, 1'b1, 1'b0};
    vt[7] = '{1'b1, 32'h3000_0000,    32'hDEAD,     32'h0000_0000, 1'b1, 1'b0};
    vt[8] = '{1'b0, STAT_A,           32'h0,        32'h0000_0002, 1'b1, 1'b0};

    // Reset values
    do_reset();
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_done", sim_done, 1'b0);
    check("reset_pass", sim_pass, 1'b0);

    // Register-level table: STATUS, exit with a failing code, ignored stores
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].we, vt[i].addr, vt[i].wdata);
      check($sformatf("vec%0d_rdata", i), mem_rdata, vt[i].exp_rdata);
      check($sformatf("vec%0d_done", i), sim_done, vt[i].exp_done);
      check($sformatf("vec%0d_pass", i), sim_pass, vt[i].exp_pass);
    end

    // Exit with the pass code, then a later store of 0 changes nothing
    do_reset();
    drive(1'b1, EXIT_A, PASS_C);
    check("exit_pass_done", sim_done, 1'b1);
    check("exit_pass_pass", sim_pass, 1'b1);
    drive(1'b1, EXIT_A, 32'h0);
    idle(1);
    check("exit_sticky_done", sim_done, 1'b1);
    check("exit_sticky_pass", sim_pass, 1'b1);

    // Exact waveform of one frame for 'A' (upper store bits must be ignored)
    do_reset();
    fv = 11'h7FF;
    fv[0]   = 1'b0;
    fv[8:1] = 8'h41;
`ifdef MMIO_UART_CONSOLE_PARITY_EN
    fv[9]  = ^fv[8:1];
    fv[10] = 1'b1;
`else
    fv[9] = 1'b1;
`endif
    drive(1'b1, LOG_A, 32'hFFFF_FF41);
    k_end = 2 + FRAME;
    for (int k = 1; k <= k_end; k++) begin
      idle(1);
      if (k < 2 || k == k_end) check($sformatf("frame_A_idle_k%0d", k), uart_tx, 1'b1);
      else check($sformatf("frame_A_bit_k%0d", k), uart_tx, fv[(k - 2) / CPB]);
    end
    drain("frame_A_drain");
    check("frame_A_last_byte", rx_last, 8'h41);

    // Ten back-to-back stores into an 8-deep FIFO: the tenth is dropped
    do_reset();
    rx0 = rx_count;
    for (int i = 0; i < 10; i++) drive(1'b1, LOG_A, 32'h30 + i);
    drive(1'b0, STAT_A, 32'h0);
    check("ovf_status_set", mem_rdata, 32'h0000_080D);
    drive(1'b1, STAT_A, 32'h8);
    drive(1'b0, STAT_A, 32'h0);
    check("ovf_status_cleared", mem_rdata, 32'h0000_0805);
    drain("ovf_drain");
    check("ovf_rx_count", rx_count - rx0, 9);
    check("ovf_last_byte", rx_last, 8'h38);
    drive(1'b0, STAT_A, 32'h0);
    check("ovf_status_idle", mem_rdata, 32'h0000_0002);

    // Randomised traffic against the reference model
    do_reset();
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      drive(1'b1, LOG_A, $urandom());
      else if (r < 68) drive(1'b0, STAT_A, $urandom());
      else if (r < 76) drive(1'b1, STAT_A, $urandom());
      else if (r < 82) drive(1'b1, LOG_A + 32'd8, $urandom());
      else if (r < 86) drive(1'b1, EXIT_A, ($urandom_range(0, 1) == 1) ? PASS_C : $urandom());
      else if (r < 91) drive(1'b0, EXIT_A, 32'h0);
      else             idle($urandom_range(0, 60));
    end
    drain("random_drain");

    // Reset in the middle of data bit 3 aborts the frame and clears the FIFO
    do_reset();
    mon_en = 0;
    drive(1'b1, LOG_A, 32'h41);
    drive(1'b1, LOG_A, 32'h5A);
    idle(17);
    check("midreset_tx_before", uart_tx, fv[4]);
    rst = 1'b1;
    cycle();
    check("midreset_tx_high", uart_tx, 1'b1);
    rst = 1'b0;
    drive(1'b0, STAT_A, 32'h0);
    check("midreset_status_empty", mem_rdata, 32'h0000_0002);
    saw_low = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (uart_tx !== 1'b1) saw_low = 1;
    end
    check("midreset_no_more_frames", saw_low, 1'b0);
    mon_en = 1;
    ch = 8'h00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_console.md
Name: mmio_uart_console

Overview:
- Synthesizable data-memory-side MMIO console. It replaces the simulation-only logger/exit model so the core's debug output leaves the chip on a real serial line.
- Byte stores to the log address are queued in a FIFO and transmitted as 8N1 UART frames.
- A store to the exit address latches a done/pass result.
- Sits on the core's data port (mem_addr/mem_wdata/mem_we/mem_rdata), beside data RAM, and is selected by address decode.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (>=2)
- FIFO_DEPTH, 8, log FIFO entries (power of 2, >=2)
- LOG_ADDR, 32'h1000_0000, byte-push register (write); STATUS is at LOG_ADDR+4
- EXIT_ADDR, 32'h2000_0000, exit register (write)
- PASS_CODE, 32'h075B_CD15, value that signals pass when written to EXIT_ADDR

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- mem_addr  in  32  core data address
- mem_wdata  in  32  core store data
- mem_we  in  1  store strobe, one cycle per store
- mem_rdata  out  32  registered read data
- uart_tx  out  1  serial output, idle high
- sim_done  out  1  sticky; exit register written
- sim_pass  out  1  sticky; exit value equalled PASS_CODE

Behaviour:
- Reset (sampled on clk rising edge while rst=1):
  - uart_tx=1, mem_rdata=0, sim_done=0, sim_pass=0.
  - FIFO empty, overflow flag 0, TX FSM in IDLE.
  - Reset mid-frame aborts the frame; uart_tx is high the cycle after reset is sampled.
- Push:
  - mem_we && mem_addr==LOG_ADDR pushes mem_wdata[7:0]. mem_wdata[31:8] are ignored.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and the overflow flag is set (sticky).
  - Push while full with a simultaneous pop is accepted; occupancy is unchanged.
- STATUS (read at LOG_ADDR+4):
  - bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow; [15:8] occupancy; other bits 0.
  - Write to STATUS with wdata[3]=1 clears overflow.
- mem_rdata: registered, one-cycle latency.
  - Equals STATUS when the previous-cycle address was LOG_ADDR+4.
  - Otherwise {31'b0, sim_done} when the previous-cycle address was EXIT_ADDR.
  - Otherwise 0.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A bit index 0..7 counts them; after bit 7 go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then IDLE; a non-empty FIFO pops in that same IDLE cycle, giving a one-cycle inter-frame gap.
  - tx_busy=1 in any state other than IDLE.
  - Push into an empty FIFO: the start bit begins 2 cycles after the store edge (1 cycle to push, 1 cycle IDLE pop).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
- Exit:
  - First mem_we && mem_addr==EXIT_ADDR sets sim_done=1 and sim_pass=(mem_wdata==PASS_CODE), one cycle after the store.
  - Both are sticky until rst; later exit writes are ignored.
  - The TX FIFO continues to drain after exit.
- Stores to other addresses are ignored. Reads of other addresses return 0.

Optional Feature:
- Macro MMIO_UART_CONSOLE_PARITY_EN.
- Defined: an even-parity state PARITY is inserted between DATA and STOP. Parity bit = XOR of the 8 data bits, held CLKS_PER_BIT cycles; frame is 11 bits.
- Undefined: 8N1, 10-bit frames, no PARITY state in the RTL.

Test Plan:
- Reset → uart_tx=1, sim_done=0, sim_pass=0, mem_rdata=0; read STATUS → 32'h0000_0002.
- Store 32'hFFFF_FF41 to LOG_ADDR with CLKS_PER_BIT=4 → start bit 2 cycles after store; serial bits 1,0,0,0,0,0,1,0; stop high. Frame is 40 cycles, 44 with parity enabled (parity bit 0 for 'A').
- Store 10 bytes back-to-back with FIFO_DEPTH=8 → 9 bytes transmitted in order, exactly one dropped, overflow=1. The first byte pops one cycle after its push, so the 10th store is the one dropped. Writing STATUS with wdata[3]=1 clears overflow.
- Store 32'h075B_CD15 to EXIT_ADDR → sim_done=1, sim_pass=1 next cycle. A subsequent store of 0 leaves both at 1.
- Store 32'h0000_0001 to EXIT_ADDR after reset → sim_done=1, sim_pass=0; read EXIT_ADDR → 1.
- Assert rst during DATA bit 3 → uart_tx=1 the next cycle, FIFO empty, no further frames emitted.
